// File: rtl/piso_stream_if.sv
// Handshake and data bundle for piso_stream.
// The master side drives the load request, the parallel word and the shift
// strobe. The slave side (the serialiser) returns ready, serial data, busy and done.
// Optional feature macro: PISO_LSB_FIRST_EN adds the lsb_first_in bit-order select.
interface piso_stream_if #(
    parameter int SIZE = 8
);
    logic [SIZE-1:0] data_in;
    logic            valid_in;
    logic            r_ready_out;
    logic            shift_en_in;
`ifdef PISO_LSB_FIRST_EN
    logic            lsb_first_in;
`endif
    logic            r_data_out;
    logic            r_busy_out;
    logic            r_done_out;

`ifdef PISO_LSB_FIRST_EN
    modport master (
        output data_in,
        output valid_in,
        output shift_en_in,
        output lsb_first_in,
        input  r_ready_out,
        input  r_data_out,
        input  r_busy_out,
        input  r_done_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        input  shift_en_in,
        input  lsb_first_in,
        output r_ready_out,
        output r_data_out,
        output r_busy_out,
        output r_done_out
    );
`else
    modport master (
        output data_in,
        output valid_in,
        output shift_en_in,
        input  r_ready_out,
        input  r_data_out,
        input  r_busy_out,
        input  r_done_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        input  shift_en_in,
        output r_ready_out,
        output r_data_out,
        output r_busy_out,
        output r_done_out
    );
`endif
endinterface

// File: rtl/piso_stream.sv
// piso_stream: parallel-in serial-out shifter with a valid/ready load, an
// external shift strobe and a one-cycle end-of-word pulse.
// A word is accepted in IDLE, its first bit appears the next cycle, and each
// strobe advances one bit. The strobe after the last bit returns the block to
// IDLE and raises done. A new word can be loaded in that same done cycle.
// Optional feature macro: PISO_LSB_FIRST_EN (per-word LSB-first order taken
// from lsb_first_in at load). Without it, words always go out MSB-first.
module piso_stream #(
    parameter int   SIZE       = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic         clk_in,
    input  logic         reset_n_in,
    piso_stream_if.slave bus
);

    localparam int CW = $clog2(SIZE);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Moves the word one place toward its output end.
    function automatic logic [SIZE-1:0] shift_word(input logic [SIZE-1:0] w,
                                                   input logic            lsb);
        logic [SIZE-1:0] r;
        if (lsb) begin
            r = {1'b0, w[SIZE-1:1]};
        end else begin
            r = {w[SIZE-2:0], 1'b0};
        end
        return r;
    endfunction

    // Returns the bit currently at the output end of the word.
    function automatic logic head_bit(input logic [SIZE-1:0] w,
                                      input logic            lsb);
        logic b;
        if (lsb) begin
            b = w[0];
        end else begin
            b = w[SIZE-1];
        end
        return b;
    endfunction

    state_t          state_q, state_d;
    logic [SIZE-1:0] shreg_q, shreg_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            lsb_q,   lsb_d;
    logic            dout_q,  dout_d;
    logic            ready_q, ready_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;

    logic            load_s;
    logic            load_lsb_s;
    logic [SIZE-1:0] shifted_s;

`ifdef PISO_LSB_FIRST_EN
    assign load_lsb_s = bus.lsb_first_in;
`else
    assign load_lsb_s = 1'b0;
`endif

    // Ready is only high in IDLE, so this also covers the done cycle.
    assign load_s    = bus.valid_in & ready_q;
    assign shifted_s = shift_word(shreg_q, lsb_q);

    // Next-state logic for the load/shift/finish sequence.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        lsb_d   = lsb_q;
        dout_d  = dout_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Strobes here are ignored; only a load moves the FSM.
                if (load_s) begin
                    state_d = ST_SHIFT;
                    shreg_d = bus.data_in;
                    lsb_d   = load_lsb_s;
                    dout_d  = head_bit(bus.data_in, load_lsb_s);
                    cnt_d   = CW'(SIZE - 1);
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bus.shift_en_in) begin
                    if (cnt_q != {CW{1'b0}}) begin
                        shreg_d = shifted_s;
                        dout_d  = head_bit(shifted_s, lsb_q);
                        cnt_d   = cnt_q - CW'(1);
                    end else begin
                        // Last bit has been held until this strobe: finish.
                        state_d = ST_IDLE;
                        dout_d  = IDLE_LEVEL;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                shreg_d = {SIZE{1'b0}};
                cnt_d   = {CW{1'b0}};
                lsb_d   = 1'b0;
                dout_d  = IDLE_LEVEL;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any word in flight.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= ST_IDLE;
            shreg_q <= {SIZE{1'b0}};
            cnt_q   <= {CW{1'b0}};
            lsb_q   <= 1'b0;
            dout_q  <= IDLE_LEVEL;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            lsb_q   <= lsb_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.r_ready_out = ready_q;
    assign bus.r_data_out  = dout_q;
    assign bus.r_busy_out  = busy_q;
    assign bus.r_done_out  = done_q;

endmodule

// File: tb/tb_piso_stream.sv
// Testbench for piso_stream (SIZE=8, IDLE_LEVEL=0): a table of per-cycle
// vectors plus hand-written sequences for hold, reset and bit-order cases.
// Builds with or without PISO_LSB_FIRST_EN.
module tb_piso_stream;

    localparam int   SIZE = 8;
    localparam logic IDLE = 1'b0;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    piso_stream_if #(.SIZE(SIZE)) bus_if ();

    piso_stream #(.SIZE(SIZE), .IDLE_LEVEL(IDLE)) dut (
        .clk_in     (clk),
        .reset_n_in (rst_n),
        .bus        (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       shift;
        logic       e_ready;
        logic       e_busy;
        logic       e_dout;
        logic       e_done;
    } vec_t;

    vec_t vecs[64];
    int   nvec;

    task automatic add_vec(input logic v, input logic [7:0] d, input logic s,
                           input logic er, input logic eb, input logic ed,
                           input logic edn);
        vecs[nvec].valid   = v;
        vecs[nvec].data    = d;
        vecs[nvec].shift   = s;
        vecs[nvec].e_ready = er;
        vecs[nvec].e_busy  = eb;
        vecs[nvec].e_dout  = ed;
        vecs[nvec].e_done  = edn;
        nvec = nvec + 1;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic er, input logic eb,
                              input logic ed, input logic edn);
        check({tag, ".ready"}, bus_if.r_ready_out, er);
        check({tag, ".busy"},  bus_if.r_busy_out,  eb);
        check({tag, ".data"},  bus_if.r_data_out,  ed);
        check({tag, ".done"},  bus_if.r_done_out,  edn);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] w;

    initial begin
        checks = 0;
        errors = 0;
        nvec   = 0;
        rst_n  = 1'b0;
        bus_if.valid_in    = 1'b0;
        bus_if.data_in     = 8'h00;
        bus_if.shift_en_in = 1'b0;
`ifdef PISO_LSB_FIRST_EN
        bus_if.lsb_first_in = 1'b0;
`endif

        // Word 8'b10101100 at full rate: 1,0,1,0,1,1,0,0 then done.
        add_vec(1'b1, 8'hAC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        add_vec(1'b0, 8'hAC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(1'b0, 8'hAC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        add_vec(1'b0, 8'hAC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(1'b0, 8'hAC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        add_vec(1'b0, 8'hAC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        add_vec(1'b0, 8'hAC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(1'b0, 8'hAC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(1'b0, 8'hAC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        add_vec(1'b0, 8'hAC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // valid held: 8'hA5 then 8'h3C, second load in the done cycle.
        add_vec(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        add_vec(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        add_vec(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        add_vec(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        add_vec(1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        add_vec(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        add_vec(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        add_vec(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        add_vec(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        add_vec(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        add_vec(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Power-on reset, then reset held 30 clocks from idle.
        repeat (3) step();
        check_outs("por", 1'b1, 1'b0, IDLE, 1'b0);
        rst_n = 1'b1;
        repeat (2) step();
        check_outs("idle", 1'b1, 1'b0, IDLE, 1'b0);
        rst_n = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            check_outs("rst30", 1'b1, 1'b0, IDLE, 1'b0);
        end
        rst_n = 1'b1;
        step();

        // Table-driven vectors.
        for (int i = 0; i < nvec; i++) begin
            bus_if.valid_in    = vecs[i].valid;
            bus_if.data_in     = vecs[i].data;
            bus_if.shift_en_in = vecs[i].shift;
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_busy,
                       vecs[i].e_dout, vecs[i].e_done);
        end
        bus_if.valid_in    = 1'b0;
        bus_if.shift_en_in = 1'b0;
        step();

        // 8'hF0 with a strobe every 4th clock; a mid-word 8'h0F request is ignored.
        w = 8'hF0;
        bus_if.valid_in = 1'b1;
        bus_if.data_in  = w;
        step();
        check_outs("slow.load", 1'b0, 1'b1, w[7], 1'b0);
        bus_if.valid_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 3; j++) begin
                bus_if.shift_en_in = 1'b0;
                bus_if.valid_in    = (k == 3 && j == 1) ? 1'b1 : 1'b0;
                bus_if.data_in     = (k == 3 && j == 1) ? 8'h0F : w;
                step();
                check_outs($sformatf("slow.hold%0d", k), 1'b0, 1'b1, w[7-k], 1'b0);
            end
            bus_if.valid_in    = 1'b0;
            bus_if.shift_en_in = 1'b1;
            step();
            if (k < 7) begin
                check_outs($sformatf("slow.bit%0d", k + 1), 1'b0, 1'b1, w[6-k], 1'b0);
            end else begin
                check_outs("slow.done", 1'b1, 1'b0, IDLE, 1'b1);
            end
        end
        bus_if.shift_en_in = 1'b0;
        step();
        check_outs("slow.after", 1'b1, 1'b0, IDLE, 1'b0);

        // Reset after the third bit of 8'hFF, then a clean 8'h81 word.
        bus_if.valid_in    = 1'b1;
        bus_if.data_in     = 8'hFF;
        bus_if.shift_en_in = 1'b1;
        step();
        bus_if.valid_in = 1'b0;
        step();
        step();
        check_outs("ff.bit3", 1'b0, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_outs("ff.rst", 1'b1, 1'b0, IDLE, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_outs("ff.rsthold", 1'b1, 1'b0, IDLE, 1'b0);
        end
        rst_n = 1'b1;
        bus_if.shift_en_in = 1'b0;
        step();
        check_outs("ff.released", 1'b1, 1'b0, IDLE, 1'b0);
        w = 8'h81;
        bus_if.valid_in    = 1'b1;
        bus_if.data_in     = w;
        bus_if.shift_en_in = 1'b1;
        step();
        check_outs("h81.bit0", 1'b0, 1'b1, w[7], 1'b0);
        bus_if.valid_in = 1'b0;
        for (int k = 1; k < 8; k++) begin
            step();
            check_outs($sformatf("h81.bit%0d", k), 1'b0, 1'b1, w[7-k], 1'b0);
        end
        step();
        check_outs("h81.done", 1'b1, 1'b0, IDLE, 1'b1);
        bus_if.shift_en_in = 1'b0;
        step();

`ifdef PISO_LSB_FIRST_EN
        // LSB-first 8'b10101100, order select toggled mid-word.
        w = 8'hAC;
        bus_if.lsb_first_in = 1'b1;
        bus_if.valid_in     = 1'b1;
        bus_if.data_in      = w;
        bus_if.shift_en_in  = 1'b1;
        step();
        check_outs("lsb.bit0", 1'b0, 1'b1, w[0], 1'b0);
        bus_if.valid_in = 1'b0;
        for (int k = 1; k < 8; k++) begin
            bus_if.lsb_first_in = ~bus_if.lsb_first_in;
            step();
            check_outs($sformatf("lsb.bit%0d", k), 1'b0, 1'b1, w[k], 1'b0);
        end
        step();
        check_outs("lsb.done", 1'b1, 1'b0, IDLE, 1'b1);
        bus_if.shift_en_in = 1'b0;
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
